rf_write_arbiter: RTL and testbench

- Shares the single write port of the 8x32 register bank between two writeback sources: requester 0 (ALU) and requester 1 (load/memory).
- Arbitrates round-robin with valid/ready handshakes and drives registered reg_write/write_reg/write_data into the bank.
- Keeps a per-register pending-write scoreboard so decode logic can stall on RAW hazards.
- Sits between the execute/memory stages and the register bank.

---
 rtl/rf_write_arbiter.sv | 115 +++++++++++
 tb/tb_rf_write_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register bank's single write port, with a
// per-register pending-write scoreboard that decode uses to stall on RAW hazards.
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   req0_valid,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [DATA_W-1:0]      req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [DATA_W-1:0]      req1_data,
  output logic                   req1_ready,
  input  logic                   reserve_valid,
  input  logic [ADDR_W-1:0]      reserve_addr,
  output logic                   reg_write,
  output logic [ADDR_W-1:0]      write_reg,
  output logic [DATA_W-1:0]      write_data,
  output logic [(1<<ADDR_W)-1:0] pending,
  output logic                   last_grant
);

  localparam int NREG = 1 << ADDR_W;

  // Handshake contract: a requester presents valid with stable addr/data and
  // holds them until it sees ready in the same cycle; valid && ready is the
  // transfer. ready is combinational and never depends on the requester's own
  // valid falling, and at most one ready is high per cycle.

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic [NREG-1:0]   r_pending;
  logic              r_last_grant;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_hs;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_wr_nz;
  logic [NREG-1:0]   w_set_mask;
  logic [NREG-1:0]   w_clr_mask;
  logic [NREG-1:0]   w_pending_nxt;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!hold) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = r_last_grant;
        w_gnt1 = !r_last_grant;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign w_hs    = w_gnt0 | w_gnt1;
  assign w_addr  = w_gnt1 ? req1_addr : req0_addr;
  assign w_data  = w_gnt1 ? req1_data : req0_data;
  assign w_wr_nz = w_hs && (w_addr != '0);

  // Set is OR-ed after clear so a same-register reservation on the write edge
  // survives: it belongs to a newer instruction.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (reserve_valid && (reserve_addr != '0))
      w_set_mask[reserve_addr] = 1'b1;
    if (w_wr_nz)
      w_clr_mask[w_addr] = 1'b1;
    w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_pending    <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_reg_write <= w_wr_nz;
      r_pending   <= w_pending_nxt;
      if (w_hs) begin
        r_write_reg  <= w_addr;
        r_write_data <= w_data;
        r_last_grant <= w_gnt1;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign reg_write  = r_reg_write;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign pending    = r_pending;
  assign last_grant = r_last_grant;

  a_one_ready: assert property (@(posedge clk) disable iff (reset)
    !(req0_ready && req1_ready));

  a_no_r0_pending: assert property (@(posedge clk) disable iff (reset)
    !pending[0]);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: stimulus pushes expected register-bank
// writes into a queue, a negedge monitor pops and compares them.
module tb_rf_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int NREG   = 1 << ADDR_W;
  localparam int QW     = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hold = 1'b0;
  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_data = '0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_data = '0;
  logic              req1_ready;
  logic              reserve_valid = 1'b0;
  logic [ADDR_W-1:0] reserve_addr = '0;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [NREG-1:0]   pending;
  logic              last_grant;

  int errors = 0;
  int checks = 0;
  logic [QW-1:0] exp_q[$];

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .pending(pending), .last_grant(last_grant)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic h, input logic rv, input logic [ADDR_W-1:0] ra);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    hold = h; reserve_valid = rv; reserve_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic expect_ready(input string name, input logic r0, input logic r1);
    @(negedge clk);
    chk({name, " req0_ready"}, 64'(req0_ready), 64'(r0));
    chk({name, " req1_ready"}, 64'(req1_ready), 64'(r1));
  endtask

  task automatic push_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (!reset && reg_write) begin
      if (exp_q.size() == 0) begin
        chk("unexpected reg_write", 64'(reg_write), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_reg", 64'(write_reg), 64'(e[QW-1:DATA_W]));
        chk("write_data", 64'(write_data), 64'(e[DATA_W-1:0]));
      end
    end
  end

  initial begin
    // reset state
    #12;
    @(negedge clk);
    chk("rst reg_write", 64'(reg_write), 64'd0);
    chk("rst write_reg", 64'(write_reg), 64'd0);
    chk("rst write_data", 64'(write_data), 64'd0);
    chk("rst pending", 64'(pending), 64'd0);
    chk("rst last_grant", 64'(last_grant), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // single write from requester 0
    drive(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    expect_ready("single", 1'b1, 1'b0);
    push_write(3'd3, 32'hDEADBEEF);
    idle();
    @(negedge clk);
    chk("single reg_write hi", 64'(reg_write), 64'd1);
    chk("single last_grant", 64'(last_grant), 64'd0);
    idle();
    @(negedge clk);
    chk("single reg_write lo", 64'(reg_write), 64'd0);

    // continuous contention from reset: grants 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22, 1'b0, 1'b0, '0);
      expect_ready("rr", (i % 2) == 0, (i % 2) == 1);
      chk("rr last_grant", 64'(last_grant), (i % 2) == 0 ? 64'd1 : 64'd0);
      if ((i % 2) == 0) push_write(3'd1, 32'h11);
      else              push_write(3'd2, 32'h22);
    end
    idle();
    @(negedge clk);
    chk("rr last_grant end", 64'(last_grant), 64'd1);

    // register-0 write is accepted but dropped
    drive(1'b1, 3'd4, 32'h44, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    expect_ready("r4", 1'b1, 1'b0);
    push_write(3'd4, 32'h44);
    drive(1'b0, '0, '0, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
    expect_ready("r0", 1'b0, 1'b1);
    chk("r0 last_grant before", 64'(last_grant), 64'd0);
    idle();
    @(negedge clk);
    chk("r0 reg_write", 64'(reg_write), 64'd0);
    chk("r0 last_grant", 64'(last_grant), 64'd1);
    chk("r0 pending", 64'(pending), 64'd0);
    chk("r0 write_reg", 64'(write_reg), 64'd0);

    // scoreboard: set, set-wins-over-clear, different-register set/clear
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 3'd5);
    drive(1'b1, 3'd5, 32'h55, 1'b0, '0, '0, 1'b0, 1'b1, 3'd5);
    chk("sb pending set", 64'(pending), 64'h20);
    expect_ready("sb w5a", 1'b1, 1'b0);
    push_write(3'd5, 32'h55);
    drive(1'b1, 3'd5, 32'h56, 1'b0, '0, '0, 1'b0, 1'b1, 3'd7);
    chk("sb set wins", 64'(pending), 64'h20);
    expect_ready("sb w5b", 1'b1, 1'b0);
    push_write(3'd5, 32'h56);
    drive(1'b1, 3'd7, 32'h77, 1'b0, '0, '0, 1'b0, 1'b1, 3'd0);
    chk("sb set+clr diff", 64'(pending), 64'h80);
    expect_ready("sb w7", 1'b1, 1'b0);
    push_write(3'd7, 32'h77);
    idle();
    @(negedge clk);
    chk("sb pending clear", 64'(pending), 64'h00);

    // hold blocks both requesters, then the other requester goes first
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22, 1'b1, 1'b0, '0);
      expect_ready("hold", 1'b0, 1'b0);
      chk("hold last_grant", 64'(last_grant), 64'd0);
      if (i > 0) chk("hold reg_write", 64'(reg_write), 64'd0);
    end
    drive(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22, 1'b0, 1'b0, '0);
    expect_ready("unhold", 1'b0, 1'b1);
    push_write(3'd2, 32'h22);
    // hold arriving after the handshake must not cancel the registered write
    drive(1'b1, 3'd1, 32'h11, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    expect_ready("hold after hs", 1'b0, 1'b0);
    chk("hold keeps write", 64'(reg_write), 64'd1);
    idle();

    // asynchronous reset mid-operation
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 3'd3);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 3'd6);
    drive(1'b1, 3'd6, 32'h66, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    chk("pre-rst pending", 64'(pending), 64'h48);
    expect_ready("w6", 1'b1, 1'b0);
    push_write(3'd6, 32'h66);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    chk("pre-rst reg_write", 64'(reg_write), 64'd1);
    chk("pre-rst write_reg", 64'(write_reg), 64'd6);
    chk("pre-rst pending after", 64'(pending), 64'h08);
    chk("pre-rst last_grant", 64'(last_grant), 64'd0);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async rst reg_write", 64'(reg_write), 64'd0);
    chk("async rst write_reg", 64'(write_reg), 64'd0);
    chk("async rst write_data", 64'(write_data), 64'd0);
    chk("async rst pending", 64'(pending), 64'd0);
    chk("async rst last_grant", 64'(last_grant), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    idle();

    @(negedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
